shift_cmd_seq: RTL and testbench

//  Command sequencer that sits directly upstream of the universal shift register (univ_shift_reg).

---
 rtl/univ_shift_pkg.sv | 29 ++
 rtl/shift_cmd_seq_if.sv | 35 +++
 rtl/shift_cmd_seq.sv | 108 ++++++++++
 tb/tb_shift_cmd_seq.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/univ_shift_pkg.sv
// univ_shift_pkg
//   Shared definitions for univ_shift_reg and its command sequencer
//   (shift_cmd_seq): register control codes, command op codes and the
//   sequencer FSM state encoding.
package univ_shift_pkg;

  // univ_shift_reg ctrl pin encoding
  localparam logic [1:0] CTRL_LOAD = 2'b00;
  localparam logic [1:0] CTRL_SHR  = 2'b01;
  localparam logic [1:0] CTRL_SHL  = 2'b10;
  localparam logic [1:0] CTRL_HOLD = 2'b11;

  // Command op codes. Shift ops deliberately share the ctrl encoding so the
  // latched op can be driven straight onto ctrl.
  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;

  // Sequencer FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic logic is_shift_op(input logic [1:0] op);
    return (op == OP_SHR) || (op == OP_SHL);
  endfunction

endpackage

// File: rtl/shift_cmd_seq_if.sv
// shift_cmd_seq_if
//   Bundles the command handshake, the serial fill-bit stream and the
//   univ_shift_reg drive pins of shift_cmd_seq.
//   master : command/stream source (drives cmd_*, ser_valid, ser_bit)
//   slave  : the sequencer (drives cmd_ready, ser_ready, ctrl, data,
//            data_l, data_h, busy, done)
interface shift_cmd_seq_if #(
  parameter int unsigned DW = 4,
  parameter int unsigned CW = 3
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [CW-1:0] cmd_cnt;
  logic [DW-1:0] cmd_data;
  logic          ser_valid;
  logic          ser_ready;
  logic          ser_bit;
  logic [1:0]    ctrl;
  logic [DW-1:0] data;
  logic          data_l;
  logic          data_h;
  logic          busy;
  logic          done;

  modport master (
    output cmd_valid, cmd_op, cmd_cnt, cmd_data, ser_valid, ser_bit,
    input  cmd_ready, ser_ready, ctrl, data, data_l, data_h, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_cnt, cmd_data, ser_valid, ser_bit,
    output cmd_ready, ser_ready, ctrl, data, data_l, data_h, busy, done
  );
endinterface

// File: rtl/shift_cmd_seq.sv
// shift_cmd_seq
//   Command sequencer sitting directly upstream of univ_shift_reg. Accepts
//   load/shift/NOP commands over a valid/ready handshake and issues them as
//   registered ctrl/data/data_l/data_h values. Shift fill bits come from a
//   serial valid/ready stream; the register is held while no bit is offered.
//   Completion is flagged by a one-cycle done pulse.
// Ports
//   clk         clock, rising edge
//   sync_rst_n  synchronous active-low reset
//   bus         shift_cmd_seq_if.slave:
//                 cmd_valid/cmd_ready/cmd_op/cmd_cnt/cmd_data  command in
//                 ser_valid/ser_ready/ser_bit                  fill-bit stream
//                 ctrl/data/data_l/data_h                      to univ_shift_reg
//                 busy, done                                   status
module shift_cmd_seq
  import univ_shift_pkg::*;
#(
  parameter int unsigned DW = 4,
  parameter int unsigned CW = 3
) (
  input logic            clk,
  input logic            sync_rst_n,
  shift_cmd_seq_if.slave bus
);

  logic [1:0]    state_q;
  logic [1:0]    dir_q;
  logic [CW-1:0] rem_q;
  logic [1:0]    ctrl_q;
  logic [DW-1:0] data_q;
  logic          data_l_q;
  logic          data_h_q;

  // FSM, remaining-shift counter and output registers share one process so
  // every ctrl value is registered in the same edge as the state it implies.
  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      state_q  <= ST_IDLE;
      dir_q    <= CTRL_HOLD;
      rem_q    <= '0;
      ctrl_q   <= CTRL_HOLD;
      data_q   <= '0;
      data_l_q <= 1'b0;
      data_h_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ctrl_q <= CTRL_HOLD;
          // cmd_ready is simply (IDLE & out of reset) here, so valid == accept
          if (bus.cmd_valid) begin
            if (bus.cmd_op == OP_LOAD) begin
              ctrl_q  <= CTRL_LOAD;
              data_q  <= bus.cmd_data;
              state_q <= ST_DONE;
            end else if (is_shift_op(bus.cmd_op) && (bus.cmd_cnt != '0)) begin
              dir_q   <= bus.cmd_op;
              rem_q   <= bus.cmd_cnt;
              state_q <= ST_SHIFT;
            end else begin
              // zero-count shift and NOP complete without touching the register
              state_q <= ST_DONE;
            end
          end
        end

        ST_SHIFT: begin
          if (bus.ser_valid) begin
            ctrl_q <= dir_q;
            if (dir_q == CTRL_SHL) data_l_q <= bus.ser_bit;
            else                   data_h_q <= bus.ser_bit;
            rem_q <= rem_q - CW'(1);
            if (rem_q == CW'(1)) state_q <= ST_DONE;
          end else begin
            ctrl_q <= CTRL_HOLD;
          end
        end

        ST_DONE: begin
          ctrl_q  <= CTRL_HOLD;
          state_q <= ST_IDLE;
        end

        default: begin
          ctrl_q  <= CTRL_HOLD;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE)  & sync_rst_n;
  assign bus.ser_ready = (state_q == ST_SHIFT) & sync_rst_n;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.ctrl      = ctrl_q;
  assign bus.data      = data_q;
  assign bus.data_l    = data_l_q;
  assign bus.data_h    = data_h_q;

  // The counter leaves SHIFT on the transfer that reaches zero, so it can
  // never be zero while shifting.
  a_rem_nonzero: assert property (@(posedge clk) disable iff (!sync_rst_n)
    (state_q == ST_SHIFT) |-> (rem_q != '0));

  a_state_legal: assert property (@(posedge clk) disable iff (!sync_rst_n)
    (state_q == ST_IDLE) || (state_q == ST_SHIFT) || (state_q == ST_DONE));

endmodule

// File: tb/tb_shift_cmd_seq.sv
// tb_shift_cmd_seq
//   Drives shift_cmd_seq with a behavioural univ_shift_reg model (q) on the
//   same clock. Issued register operations are predicted into a scoreboard
//   queue when a command is driven and popped as ctrl shows them.
module tb_shift_cmd_seq;
  import univ_shift_pkg::*;

  localparam int unsigned DW = 4;
  localparam int unsigned CW = 3;

  typedef struct packed {
    logic [1:0]    ctrl;
    logic          fill;
    logic [DW-1:0] data;
    logic [DW-1:0] q;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  exp_t exp_q[$];

  shift_cmd_seq_if #(.DW(DW), .CW(CW)) sif ();

  shift_cmd_seq #(.DW(DW), .CW(CW)) dut (
    .clk        (clk),
    .sync_rst_n (rst_n),
    .bus        (sif)
  );

  always #5 clk = ~clk;

  // univ_shift_reg model: applies ctrl/data registered at the previous edge
  logic [DW-1:0] q = '0;
  always @(posedge clk) begin
    case (sif.ctrl)
      CTRL_LOAD: q <= sif.data;
      CTRL_SHR:  q <= {sif.data_h, q[DW-1:1]};
      CTRL_SHL:  q <= {q[DW-2:0], sif.data_l};
      default:   ;
    endcase
  end

  task automatic test_reset();
    rst_n         = 1'b0;
    sif.cmd_valid = 1'b0;
    sif.cmd_op    = OP_NOP;
    sif.cmd_cnt   = '0;
    sif.cmd_data  = '0;
    sif.ser_valid = 1'b0;
    sif.ser_bit   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (sif.ctrl !== CTRL_HOLD) begin n_bad++; $display("FAIL rst_ctrl: got %b want 11", sif.ctrl); end
    n_cmp++; if (sif.data !== 4'b0000) begin n_bad++; $display("FAIL rst_data: got %b want 0000", sif.data); end
    n_cmp++; if (sif.data_l !== 1'b0 || sif.data_h !== 1'b0) begin n_bad++; $display("FAIL rst_fill: got %b%b want 00", sif.data_l, sif.data_h); end
    n_cmp++; if (sif.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_cmd_ready: got %b want 0", sif.cmd_ready); end
    n_cmp++; if (sif.ser_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ser_ready: got %b want 0", sif.ser_ready); end
    n_cmp++; if (sif.done !== 1'b0 || sif.busy !== 1'b0) begin n_bad++; $display("FAIL rst_status: done %b busy %b want 0 0", sif.done, sif.busy); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (sif.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rel_cmd_ready: got %b want 1", sif.cmd_ready); end
  endtask

  task automatic test_load();
    exp_t e;
    @(negedge clk);
    exp_q.push_back(exp_t'{ctrl: CTRL_LOAD, fill: 1'b0, data: 4'b1011, q: 4'b1011});
    sif.cmd_valid = 1'b1;
    sif.cmd_op    = OP_LOAD;
    sif.cmd_data  = 4'b1011;
    @(negedge clk);
    sif.cmd_valid = 1'b0;
    e = exp_q.pop_front();
    n_cmp++; if (sif.ctrl !== e.ctrl || sif.data !== e.data) begin n_bad++; $display("FAIL load_issue: ctrl %b data %b want %b %b", sif.ctrl, sif.data, e.ctrl, e.data); end
    n_cmp++; if (sif.done !== 1'b1) begin n_bad++; $display("FAIL load_done: got %b want 1", sif.done); end
    @(negedge clk);
    n_cmp++; if (sif.ctrl !== CTRL_HOLD || sif.done !== 1'b0) begin n_bad++; $display("FAIL load_after: ctrl %b done %b want 11 0", sif.ctrl, sif.done); end
    n_cmp++; if (q !== e.q) begin n_bad++; $display("FAIL load_q: got %b want %b", q, e.q); end
    n_cmp++; if (sif.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL load_ready: got %b want 1", sif.cmd_ready); end
  endtask

  task automatic test_shl_b2b();
    logic [2:0] bits = 3'b101;  // bits[0]=1, bits[1]=0, bits[2]=1
    int unsigned k = 0, dones = 0, holds = 0;
    bit hs, acc, qpend = 0, fin = 0;
    logic [DW-1:0] qexp = '0;
    exp_t e;
    @(negedge clk);
    exp_q.push_back(exp_t'{ctrl: CTRL_SHL, fill: 1'b1, data: '0, q: 4'b0111});
    exp_q.push_back(exp_t'{ctrl: CTRL_SHL, fill: 1'b0, data: '0, q: 4'b1110});
    exp_q.push_back(exp_t'{ctrl: CTRL_SHL, fill: 1'b1, data: '0, q: 4'b1101});
    sif.cmd_valid = 1'b1;
    sif.cmd_op    = OP_SHL;
    sif.cmd_cnt   = 3'd3;
    sif.ser_valid = 1'b1;
    sif.ser_bit   = bits[0];
    for (int unsigned cyc = 0; cyc < 40 && !fin; cyc++) begin
      hs  = sif.ser_valid & sif.ser_ready;
      acc = sif.cmd_valid & sif.cmd_ready;
      @(negedge clk);
      if (acc) sif.cmd_valid = 1'b0;
      if (hs) k++;
      if (qpend) begin
        n_cmp++; if (q !== qexp) begin n_bad++; $display("FAIL shl_q: got %b want %b", q, qexp); end
        qpend = 0;
      end
      if (sif.ctrl !== CTRL_HOLD) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL shl_extra_issue: got ctrl %b want 11", sif.ctrl);
        end else begin
          e = exp_q.pop_front();
          if (sif.ctrl !== e.ctrl || sif.data_l !== e.fill) begin
            n_bad++; $display("FAIL shl_issue: ctrl %b data_l %b want %b %b", sif.ctrl, sif.data_l, e.ctrl, e.fill);
          end
          qpend = 1; qexp = e.q;
        end
      end else if (sif.busy && !sif.done) holds++;
      if (sif.done) dones++;
      if (k >= 3) sif.ser_valid = 1'b0;
      else        sif.ser_bit   = bits[k];
      fin = (dones != 0) && !qpend;
    end
    n_cmp++; if (!fin) begin n_bad++; $display("FAIL shl_timeout: dones %0d want 1", dones); end
    n_cmp++; if (dones != 1) begin n_bad++; $display("FAIL shl_done_count: got %0d want 1", dones); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL shl_missing: %0d left want 0", exp_q.size()); end
    n_cmp++; if (holds != 1) begin n_bad++; $display("FAIL shl_holds: got %0d want 1", holds); end
    exp_q.delete();
  endtask

  task automatic test_shr_gap();
    logic [1:0] bits = 2'b10;  // bits[0]=0, bits[1]=1
    int unsigned k = 0, dones = 0, holds = 0, gap = 0;
    bit hs, acc, qpend = 0, fin = 0;
    logic [DW-1:0] qexp = '0;
    exp_t e;
    @(negedge clk);
    exp_q.push_back(exp_t'{ctrl: CTRL_SHR, fill: 1'b0, data: '0, q: 4'b0110});
    exp_q.push_back(exp_t'{ctrl: CTRL_SHR, fill: 1'b1, data: '0, q: 4'b1011});
    sif.cmd_valid = 1'b1;
    sif.cmd_op    = OP_SHR;
    sif.cmd_cnt   = 3'd2;
    sif.ser_valid = 1'b1;
    sif.ser_bit   = bits[0];
    for (int unsigned cyc = 0; cyc < 40 && !fin; cyc++) begin
      hs  = sif.ser_valid & sif.ser_ready;
      acc = sif.cmd_valid & sif.cmd_ready;
      @(negedge clk);
      if (acc) sif.cmd_valid = 1'b0;
      if (hs) begin k++; gap = 2; end
      if (qpend) begin
        n_cmp++; if (q !== qexp) begin n_bad++; $display("FAIL shr_q: got %b want %b", q, qexp); end
        qpend = 0;
      end
      if (sif.ctrl !== CTRL_HOLD) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL shr_extra_issue: got ctrl %b want 11", sif.ctrl);
        end else begin
          e = exp_q.pop_front();
          if (sif.ctrl !== e.ctrl || sif.data_h !== e.fill) begin
            n_bad++; $display("FAIL shr_issue: ctrl %b data_h %b want %b %b", sif.ctrl, sif.data_h, e.ctrl, e.fill);
          end
          qpend = 1; qexp = e.q;
        end
      end else if (sif.busy && !sif.done) holds++;
      if (sif.done) dones++;
      if (k >= 2) sif.ser_valid = 1'b0;
      else if (gap > 0) begin sif.ser_valid = 1'b0; gap--; end
      else begin sif.ser_valid = 1'b1; sif.ser_bit = bits[k]; end
      fin = (dones != 0) && !qpend;
    end
    n_cmp++; if (!fin) begin n_bad++; $display("FAIL shr_timeout: dones %0d want 1", dones); end
    n_cmp++; if (dones != 1) begin n_bad++; $display("FAIL shr_done_count: got %0d want 1", dones); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL shr_missing: %0d left want 0", exp_q.size()); end
    n_cmp++; if (holds != 3) begin n_bad++; $display("FAIL shr_gap_holds: got %0d want 3", holds); end
    exp_q.delete();
  endtask

  task automatic test_zero_nop();
    logic [1:0] ops = {OP_NOP[0], OP_SHL[0]};
    logic [1:0] op;
    for (int unsigned i = 0; i < 2; i++) begin
      op = (i == 0) ? OP_SHL : OP_NOP;
      @(negedge clk);
      sif.cmd_valid = 1'b1;
      sif.cmd_op    = op;
      sif.cmd_cnt   = '0;
      sif.ser_valid = ops[i];  // a stray fill bit must be ignored
      sif.ser_bit   = 1'b1;
      @(negedge clk);
      sif.cmd_valid = 1'b0;
      n_cmp++; if (sif.done !== 1'b1 || sif.ctrl !== CTRL_HOLD) begin n_bad++; $display("FAIL zn%0d_done: done %b ctrl %b want 1 11", i, sif.done, sif.ctrl); end
      n_cmp++; if (sif.ser_ready !== 1'b0) begin n_bad++; $display("FAIL zn%0d_ser_ready: got %b want 0", i, sif.ser_ready); end
      @(negedge clk);
      sif.ser_valid = 1'b0;
      n_cmp++; if (sif.done !== 1'b0 || sif.ctrl !== CTRL_HOLD) begin n_bad++; $display("FAIL zn%0d_after: done %b ctrl %b want 0 11", i, sif.done, sif.ctrl); end
      n_cmp++; if (q !== 4'b1011) begin n_bad++; $display("FAIL zn%0d_q: got %b want 1011", i, q); end
    end
  endtask

  task automatic test_reset_mid();
    int unsigned dones = 0;
    @(negedge clk);
    sif.cmd_valid = 1'b1;
    sif.cmd_op    = OP_SHL;
    sif.cmd_cnt   = 3'd3;
    sif.ser_valid = 1'b1;
    sif.ser_bit   = 1'b1;
    @(negedge clk);
    sif.cmd_valid = 1'b0;
    n_cmp++; if (sif.busy !== 1'b1 || sif.ctrl !== CTRL_HOLD) begin n_bad++; $display("FAIL rm_start: busy %b ctrl %b want 1 11", sif.busy, sif.ctrl); end
    sif.ser_bit = 1'b1;
    @(negedge clk);
    n_cmp++; if (sif.ctrl !== CTRL_SHL || sif.data_l !== 1'b1) begin n_bad++; $display("FAIL rm_first: ctrl %b data_l %b want 10 1", sif.ctrl, sif.data_l); end
    sif.ser_bit = 1'b0;
    rst_n = 1'b0;
    for (int unsigned i = 0; i < 2; i++) begin
      @(negedge clk);
      if (sif.done) dones++;
      n_cmp++; if (sif.ctrl !== CTRL_HOLD) begin n_bad++; $display("FAIL rm_ctrl%0d: got %b want 11", i, sif.ctrl); end
      n_cmp++; if (sif.ser_ready !== 1'b0 || sif.busy !== 1'b0) begin n_bad++; $display("FAIL rm_ready%0d: ser_ready %b busy %b want 0 0", i, sif.ser_ready, sif.busy); end
    end
    rst_n = 1'b1;
    sif.ser_valid = 1'b0;
    @(negedge clk);
    if (sif.done) dones++;
    n_cmp++; if (q !== 4'b0111) begin n_bad++; $display("FAIL rm_q: got %b want 0111", q); end
    n_cmp++; if (dones != 0) begin n_bad++; $display("FAIL rm_done: got %0d pulses want 0", dones); end
    n_cmp++; if (sif.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rm_ready_after: got %b want 1", sif.cmd_ready); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_shl_b2b();
    test_shr_gap();
    test_zero_nop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
